scan_scheduler: RTL and testbench

Sequences the servo/sonar datapath for automatic scanning. Steps the servo angle between two bounds in a ping-pong sweep, waits for mechanical settling, fires one sonar measurement per position, and presents each (angle, distance) pair on a valid/ready stream toward the UART telemetry path. Sits between the command control unit (which supplies bounds, step and enable) and the servo/sonar drivers.

---
 rtl/scan_pkg.sv | 72 +++++++
 rtl/cycle_timer.sv | 30 +++
 rtl/scan_scheduler.sv | 234 +++++++++++++++++++++++
 tb/tb_scan_scheduler.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared constants, FSM encoding and sweep arithmetic for scan_scheduler.
package scan_pkg;

    localparam int ANGLE_W = 8;
    localparam int STEP_W  = 4;
    localparam logic [ANGLE_W-1:0] DIST_TIMEOUT = 8'hFF;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_MOVE      = 3'd1;
    localparam logic [2:0] ST_SETTLE    = 3'd2;
    localparam logic [2:0] ST_TRIGGER   = 3'd3;
    localparam logic [2:0] ST_WAIT_ECHO = 3'd4;
    localparam logic [2:0] ST_PRESENT   = 3'd5;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    typedef struct packed {
        logic [ANGLE_W-1:0] angle;
        logic               dir;
    } sweep_pos_t;

    // Ping-pong step with a carry/borrow bit so the angle saturates at the bounds instead of wrapping.
    function automatic sweep_pos_t next_position(
        input logic [ANGLE_W-1:0] angle,
        input logic               dir,
        input logic [ANGLE_W-1:0] lo,
        input logic [ANGLE_W-1:0] hi,
        input logic [STEP_W-1:0]  step
    );
        sweep_pos_t               res;
        logic [ANGLE_W:0]         up_sum;
        logic signed [ANGLE_W+1:0] dn_sum;
        up_sum = {1'b0, angle} + {{(ANGLE_W+1-STEP_W){1'b0}}, step};
        dn_sum = $signed({2'b00, angle}) - $signed({{(ANGLE_W+2-STEP_W){1'b0}}, step});
        if (dir == DIR_UP) begin
            if (up_sum >= {1'b0, hi}) begin
                res.angle = hi;
                res.dir   = DIR_DOWN;
            end else begin
                res.angle = up_sum[ANGLE_W-1:0];
                res.dir   = DIR_UP;
            end
        end else begin
            if (dn_sum <= $signed({2'b00, lo})) begin
                res.angle = lo;
                res.dir   = DIR_UP;
            end else begin
                res.angle = dn_sum[ANGLE_W-1:0];
                res.dir   = DIR_DOWN;
            end
        end
        return res;
    endfunction

    function automatic logic [ANGLE_W-1:0] clamp_angle(
        input logic [ANGLE_W-1:0] angle,
        input logic [ANGLE_W-1:0] lo,
        input logic [ANGLE_W-1:0] hi
    );
        logic [ANGLE_W-1:0] res;
        if (angle < lo) begin
            res = lo;
        end else if (angle > hi) begin
            res = hi;
        end else begin
            res = angle;
        end
        return res;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter that saturates at zero and flags when it gets there.
module cycle_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count_r;

    // Load has priority over decrement; counting stops at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {WIDTH{1'b0}};
        end else if (load) begin
            count_r <= load_value;
        end else if (dec && (count_r != {WIDTH{1'b0}})) begin
            count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/scan_scheduler.sv
// Automatic ping-pong servo sweep with one sonar sample per position on a valid/ready stream.
// Optional echo timeout is built when SCAN_TIMEOUT_EN is defined.
module scan_scheduler
    import scan_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 50000,
    parameter int TIMEOUT_CYCLES = 600000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [ANGLE_W-1:0] start_angle,
    input  logic [ANGLE_W-1:0] end_angle,
    input  logic [STEP_W-1:0]  step,
    output logic [ANGLE_W-1:0] servo_angle,
    output logic               sonar_measure,
    input  logic               sonar_ready,
    input  logic [ANGLE_W-1:0] sonar_distance,
    output logic               sample_valid,
    input  logic               sample_ready,
    output logic [ANGLE_W-1:0] sample_angle,
    output logic [ANGLE_W-1:0] sample_distance,
    output logic               sample_timeout,
    output logic               sweep_done,
    output logic               busy
);

    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

    logic [2:0]         state_r;
    logic [2:0]         next_state_s;
    logic [ANGLE_W-1:0] angle_r;
    logic               dir_r;
    logic               moved_r;
    logic [ANGLE_W-1:0] lo_r;
    logic [ANGLE_W-1:0] hi_r;
    logic [STEP_W-1:0]  step_r;
    logic               sonar_measure_r;
    logic               sample_valid_r;
    logic [ANGLE_W-1:0] sample_angle_r;
    logic [ANGLE_W-1:0] sample_distance_r;
    logic               sample_timeout_r;
    logic               sweep_done_r;
    logic               busy_r;

    logic [ANGLE_W-1:0] in_lo_s;
    logic [ANGLE_W-1:0] in_hi_s;
    logic [STEP_W-1:0]  in_step_s;
    logic               handshake_s;
    logic               bound_hit_s;
    logic               settle_load_s;
    logic               settle_dec_s;
    logic               settle_zero_s;
    logic               timeout_hit_s;
    sweep_pos_t         next_pos_s;
    logic [ANGLE_W-1:0] next_angle_s;

    // Normalise the command inputs into ordered bounds and a non-zero step.
    always_comb begin
        in_lo_s   = start_angle;
        in_hi_s   = end_angle;
        in_step_s = step;
        if (start_angle > end_angle) begin
            in_lo_s = end_angle;
            in_hi_s = start_angle;
        end else begin
            in_lo_s = start_angle;
            in_hi_s = end_angle;
        end
        if (step == 4'd0) begin
            in_step_s = 4'd1;
        end else begin
            in_step_s = step;
        end
    end

    assign handshake_s = (state_r == ST_PRESENT) && sample_ready;

    // A bound counts as reached only after a step landed on it; the start position does not.
    always_comb begin
        bound_hit_s = 1'b0;
        if (lo_r == hi_r) begin
            bound_hit_s = 1'b1;
        end else if (moved_r) begin
            bound_hit_s = (dir_r == DIR_DOWN) ? (angle_r == hi_r) : (angle_r == lo_r);
        end else begin
            bound_hit_s = 1'b0;
        end
    end

    assign next_pos_s   = next_position(angle_r, dir_r, lo_r, hi_r, step_r);
    assign next_angle_s = bound_hit_s ? clamp_angle(next_pos_s.angle, in_lo_s, in_hi_s)
                                      : next_pos_s.angle;

    assign settle_load_s = (state_r == ST_MOVE);
    assign settle_dec_s  = (state_r == ST_SETTLE);

    cycle_timer #(
        .WIDTH (SETTLE_W)
    ) u_settle_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (settle_load_s),
        .load_value (SETTLE_LOAD),
        .dec        (settle_dec_s),
        .zero       (settle_zero_s)
    );

`ifdef SCAN_TIMEOUT_EN
    localparam int TIMEOUT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LOAD = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic timeout_load_s;
    logic timeout_dec_s;
    logic timeout_zero_s;

    assign timeout_load_s = (state_r == ST_TRIGGER);
    assign timeout_dec_s  = (state_r == ST_WAIT_ECHO);

    cycle_timer #(
        .WIDTH (TIMEOUT_W)
    ) u_timeout_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timeout_load_s),
        .load_value (TIMEOUT_LOAD),
        .dec        (timeout_dec_s),
        .zero       (timeout_zero_s)
    );

    // An echo arriving on the expiry cycle still wins over the timeout.
    assign timeout_hit_s = (state_r == ST_WAIT_ECHO) && timeout_zero_s && !sonar_ready;
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Sequencer next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE:      next_state_s = enable ? ST_MOVE : ST_IDLE;
            ST_MOVE:      next_state_s = ST_SETTLE;
            ST_SETTLE:    next_state_s = settle_zero_s ? ST_TRIGGER : ST_SETTLE;
            ST_TRIGGER:   next_state_s = ST_WAIT_ECHO;
            ST_WAIT_ECHO: next_state_s = (sonar_ready || timeout_hit_s) ? ST_PRESENT : ST_WAIT_ECHO;
            ST_PRESENT: begin
                if (sample_ready) begin
                    next_state_s = enable ? ST_MOVE : ST_IDLE;
                end else begin
                    next_state_s = ST_PRESENT;
                end
            end
            default:      next_state_s = ST_IDLE;
        endcase
    end

    // State, sweep position and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r           <= ST_IDLE;
            angle_r           <= 8'h00;
            dir_r             <= DIR_UP;
            moved_r           <= 1'b0;
            lo_r              <= 8'h00;
            hi_r              <= 8'h00;
            step_r            <= 4'd1;
            sonar_measure_r   <= 1'b0;
            sample_valid_r    <= 1'b0;
            sample_angle_r    <= 8'h00;
            sample_distance_r <= 8'h00;
            sample_timeout_r  <= 1'b0;
            sweep_done_r      <= 1'b0;
            busy_r            <= 1'b0;
        end else begin
            state_r         <= next_state_s;
            busy_r          <= (next_state_s != ST_IDLE);
            sonar_measure_r <= (next_state_s == ST_TRIGGER);
            sweep_done_r    <= handshake_s && bound_hit_s;
            case (state_r)
                ST_IDLE: begin
                    if (enable) begin
                        lo_r    <= in_lo_s;
                        hi_r    <= in_hi_s;
                        step_r  <= in_step_s;
                        angle_r <= in_lo_s;
                        dir_r   <= DIR_UP;
                        moved_r <= 1'b0;
                    end
                end
                ST_WAIT_ECHO: begin
                    if (sonar_ready) begin
                        sample_valid_r    <= 1'b1;
                        sample_angle_r    <= angle_r;
                        sample_distance_r <= sonar_distance;
                        sample_timeout_r  <= 1'b0;
                    end else if (timeout_hit_s) begin
                        sample_valid_r    <= 1'b1;
                        sample_angle_r    <= angle_r;
                        sample_distance_r <= DIST_TIMEOUT;
                        sample_timeout_r  <= 1'b1;
                    end
                end
                ST_PRESENT: begin
                    if (sample_ready) begin
                        sample_valid_r <= 1'b0;
                        if (enable) begin
                            angle_r <= next_angle_s;
                            dir_r   <= next_pos_s.dir;
                            moved_r <= 1'b1;
                            if (bound_hit_s) begin
                                lo_r   <= in_lo_s;
                                hi_r   <= in_hi_s;
                                step_r <= in_step_s;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign servo_angle     = angle_r;
    assign sonar_measure   = sonar_measure_r;
    assign sample_valid    = sample_valid_r;
    assign sample_angle    = sample_angle_r;
    assign sample_distance = sample_distance_r;
    assign sample_timeout  = sample_timeout_r;
    assign sweep_done      = sweep_done_r;
    assign busy            = busy_r;

endmodule

// File: tb/tb_scan_scheduler.sv
// Self-checking bench for scan_scheduler: plan vectors, randomized sweeps vs. a ping-pong model, corner sequences.
module tb_scan_scheduler;

    localparam int S  = 4;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] start_angle;
    logic [7:0] end_angle;
    logic [3:0] step;
    logic [7:0] servo_angle;
    logic       sonar_measure;
    logic       sonar_ready;
    logic [7:0] sonar_distance;
    logic       sample_valid;
    logic       sample_ready;
    logic [7:0] sample_angle;
    logic [7:0] sample_distance;
    logic       sample_timeout;
    logic       sweep_done;
    logic       busy;

    always #5 clk = ~clk;

    scan_scheduler #(
        .SETTLE_CYCLES  (S),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .start_angle     (start_angle),
        .end_angle       (end_angle),
        .step            (step),
        .servo_angle     (servo_angle),
        .sonar_measure   (sonar_measure),
        .sonar_ready     (sonar_ready),
        .sonar_distance  (sonar_distance),
        .sample_valid    (sample_valid),
        .sample_ready    (sample_ready),
        .sample_angle    (sample_angle),
        .sample_distance (sample_distance),
        .sample_timeout  (sample_timeout),
        .sweep_done      (sweep_done),
        .busy            (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sonar responder: answers each measure pulse after echo_delay cycles, optionally glitching during TRIGGER.
    int         echo_delay = 1;
    bit         echo_en    = 1'b1;
    bit         echo_early = 1'b0;
    logic [7:0] echo_d;
    logic [7:0] dist_q[$];

    initial begin
        sonar_ready    = 1'b0;
        sonar_distance = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (sonar_measure === 1'b1 && echo_en) begin
                echo_d = 8'($urandom_range(0, 200));
                if (echo_early) begin
                    sonar_ready    = 1'b1;
                    sonar_distance = 8'hEE;
                    @(posedge clk); #1;
                    sonar_ready = 1'b0;
                end else begin
                    @(posedge clk); #1;
                end
                repeat (echo_delay - 1) begin
                    @(posedge clk); #1;
                end
                sonar_distance = echo_d;
                sonar_ready    = 1'b1;
                dist_q.push_back(echo_d);
                @(posedge clk); #1;
                sonar_ready = 1'b0;
            end
        end
    end

    // Wait for one sample, check it (plus stability under backpressure), then hand it off.
    task automatic get_sample(input logic [7:0] exp_angle, input bit exp_done, input bit exp_to,
                              input int stall, input bit last);
        int         waited = 0;
        logic [7:0] exp_dist;
        while (sample_valid !== 1'b1 && waited < 300) begin
            @(posedge clk); #1;
            waited++;
        end
        check("sample_wait", 32'(sample_valid), 32'd1);
        if (sample_valid !== 1'b1) return;
        if (exp_to) begin
            exp_dist = 8'hFF;
        end else begin
            check("dist_queue", 32'(dist_q.size() > 0), 32'd1);
            exp_dist = (dist_q.size() > 0) ? dist_q.pop_front() : 8'h00;
        end
        check("sample_angle", 32'(sample_angle), 32'(exp_angle));
        check("sample_distance", 32'(sample_distance), 32'(exp_dist));
        check("sample_timeout", 32'(sample_timeout), 32'(exp_to));
        repeat (stall) begin
            @(posedge clk); #1;
            check("stall_valid", 32'(sample_valid), 32'd1);
            check("stall_angle", 32'(sample_angle), 32'(exp_angle));
            check("stall_distance", 32'(sample_distance), 32'(exp_dist));
            check("stall_no_measure", 32'(sonar_measure), 32'd0);
        end
        if (last) enable = 1'b0;
        sample_ready = 1'b1;
        @(posedge clk); #1;
        sample_ready = 1'b0;
        check("valid_drop", 32'(sample_valid), 32'd0);
        check("sweep_done", 32'(sweep_done), 32'(exp_done));
        if (last) check("busy_after_last", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("sweep_done_pulse", 32'(sweep_done), 32'd0);
    endtask

    typedef struct {
        logic [7:0]  start_a;
        logic [7:0]  end_a;
        logic [3:0]  stp;
        int          n;
        logic [7:0]  angles [16];
        logic [15:0] done;
    } vec_t;

    vec_t vecs[3];

    logic [7:0] exp_a[32];
    bit         exp_d[32];

    // Ping-pong reference: bounce between lo and hi, a sample at a bound pulses unless it is the start point.
    task automatic build_model(input int lo, input int hi, input int st, input int n);
        int pos, dir, p;
        if (st == 0) st = 1;
        pos = lo;
        dir = 1;
        for (int i = 0; i < n; i++) begin
            exp_a[i] = 8'(pos);
            exp_d[i] = ((pos == lo) || (pos == hi)) && ((i > 0) || (lo == hi));
            p = pos + dir * st;
            if (p >= hi) begin
                pos = hi;
                dir = -1;
            end else if (p <= lo) begin
                pos = lo;
                dir = 1;
            end else begin
                pos = p;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, bad, lo, hi, st;

        vecs[0] = '{8'h40, 8'h10, 4'd8, 14,
                    '{8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38, 8'h40, 8'h38,
                      8'h30, 8'h28, 8'h20, 8'h18, 8'h10, 8'h18, 8'h00, 8'h00}, 16'h1040};
        vecs[1] = '{8'hF8, 8'hFF, 4'd5, 6,
                    '{8'hF8, 8'hFD, 8'hFF, 8'hFA, 8'hF8, 8'hFD, 8'h00, 8'h00,
                      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 16'h0014};
        vecs[2] = '{8'h80, 8'h80, 4'd0, 5,
                    '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h00, 8'h00,
                      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 16'h001F};

        rst = 1'b1; enable = 1'b0; start_angle = 8'h00; end_angle = 8'h00; step = 4'd0;
        sample_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_servo_angle", 32'(servo_angle), 32'h0);
        check("rst_sonar_measure", 32'(sonar_measure), 32'h0);
        check("rst_sample_valid", 32'(sample_valid), 32'h0);
        check("rst_sample_angle", 32'(sample_angle), 32'h0);
        check("rst_sample_distance", 32'(sample_distance), 32'h0);
        check("rst_sample_timeout", 32'(sample_timeout), 32'h0);
        check("rst_sweep_done", 32'(sweep_done), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Start latency, measure pulse width and echo-to-valid latency.
        start_angle = 8'h30; end_angle = 8'h20; step = 4'd4; echo_delay = 1; enable = 1'b1;
        @(posedge clk); #1;
        check("start_servo_lo", 32'(servo_angle), 32'h20);
        check("start_busy", 32'(busy), 32'd1);
        k = 1;
        while (sonar_measure !== 1'b1 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("measure_latency", 32'(k), 32'(S + 2));
        @(posedge clk); #1;
        check("measure_one_cycle", 32'(sonar_measure), 32'd0);
        check("valid_before_echo", 32'(sample_valid), 32'd0);
        @(posedge clk); #1;
        check("echo_to_valid", 32'(sample_valid), 32'd1);
        get_sample(8'h20, 1'b0, 1'b0, 0, 1'b1);

        // Plan vectors.
        for (int v = 0; v < 3; v++) begin
            start_angle = vecs[v].start_a; end_angle = vecs[v].end_a; step = vecs[v].stp;
            echo_delay  = $urandom_range(1, 4);
            echo_early  = (v == 1);
            enable      = 1'b1;
            for (int i = 0; i < vecs[v].n; i++) begin
                get_sample(vecs[v].angles[i], vecs[v].done[i], 1'b0,
                           (v == 0 && i == 3) ? 20 : int'($urandom_range(0, 3)),
                           i == vecs[v].n - 1);
            end
        end
        echo_early = 1'b0;

        // Randomized sweeps against the model.
        for (int r = 0; r < 4; r++) begin
            start_angle = 8'($urandom); end_angle = 8'($urandom); step = 4'($urandom);
            lo = (start_angle < end_angle) ? int'(start_angle) : int'(end_angle);
            hi = (start_angle < end_angle) ? int'(end_angle) : int'(start_angle);
            st = int'(step);
            build_model(lo, hi, st, 20);
            echo_delay = $urandom_range(1, 5);
            enable     = 1'b1;
            for (int i = 0; i < 20; i++) begin
                get_sample(exp_a[i], exp_d[i], 1'b0, $urandom_range(0, 2), i == 19);
            end
        end

        // Enable dropped during WAIT_ECHO: pending sample still delivered, then idle.
        start_angle = 8'h50; end_angle = 8'h60; step = 4'd2; echo_delay = 5; enable = 1'b1;
        k = 0;
        while (sonar_measure !== 1'b1 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("drop_measure_seen", 32'(sonar_measure), 32'd1);
        @(posedge clk); #1;
        enable = 1'b0;
        get_sample(8'h50, 1'b0, 1'b0, 0, 1'b1);
        bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (sonar_measure !== 1'b0 || sample_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("idle_after_drop", 32'(bad), 32'd0);

        // Reset asserted in SETTLE aborts with no sample.
        start_angle = 8'h10; end_angle = 8'h90; step = 4'd3; enable = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("settle_busy", 32'(busy), 32'd1);
        rst = 1'b1; enable = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_servo_angle", 32'(servo_angle), 32'h0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_sample_valid", 32'(sample_valid), 32'd0);
        check("midrst_measure", 32'(sonar_measure), 32'd0);
        bad = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (sonar_measure !== 1'b0 || sample_valid !== 1'b0) bad++;
        end
        check("no_sample_after_reset", 32'(bad), 32'd0);

`ifdef SCAN_TIMEOUT_EN
        // No echo: timeout samples carry FF and the scan keeps going.
        echo_en = 1'b0;
        start_angle = 8'h70; end_angle = 8'h78; step = 4'd8; enable = 1'b1;
        get_sample(8'h70, 1'b0, 1'b1, 0, 1'b0);
        get_sample(8'h78, 1'b1, 1'b1, 0, 1'b1);
        echo_en = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
